// File: rtl/ahb3lite_cmd_master.sv
// AHB3-Lite burst master: turns one command into a pipelined
// sequence of NONSEQ/SEQ transfers with error abort.
module ahb3lite_cmd_master #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [HADDR_SIZE-1:0] cmd_addr_i,
    input  logic                  cmd_write_i,
    input  logic [2:0]            cmd_size_i,
    input  logic [2:0]            cmd_burst_i,
    input  logic [HDATA_SIZE-1:0] wdata_i,
    output logic                  wdata_ack_o,
    output logic [HDATA_SIZE-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    output logic [HDATA_SIZE-1:0] HWDATA,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [HADDR_SIZE-1:0] haddr_q, haddr_d;
    logic [1:0]            htrans_q, htrans_d;
    logic                  hwrite_q, hwrite_d;
    logic [2:0]            hsize_q, hsize_d;
    logic [2:0]            hburst_q, hburst_d;
    logic [3:0]            left_q, left_d;
    logic                  dphase_q, dphase_d;
    logic [HDATA_SIZE-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [HADDR_SIZE-1:0] step;

    function automatic logic [3:0] last_beat(input logic [2:0] b);
        unique case (b)
            3'b011:  last_beat = 4'd3;
            3'b101:  last_beat = 4'd7;
            3'b111:  last_beat = 4'd15;
            default: last_beat = 4'd0;
        endcase
    endfunction

    assign step = {{(HADDR_SIZE-1){1'b0}}, 1'b1} << hsize_q;

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        hburst_d = hburst_q;
        left_d   = left_q;
        dphase_d = dphase_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                htrans_d = TR_IDLE;
                dphase_d = 1'b0;
                if (cmd_valid_i && cmd_ready_o) begin
                    haddr_d  = cmd_addr_i;
                    hwrite_d = cmd_write_i;
                    hsize_d  = cmd_size_i;
                    hburst_d = cmd_burst_i;
                    left_d   = last_beat(cmd_burst_i);
                    htrans_d = TR_NONSEQ;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR, ST_DATA: begin
                if (dphase_q && HRESP) begin
                    // pending address phase is dropped on ERROR
                    htrans_d = TR_IDLE;
                    dphase_d = 1'b0;
                    if (HREADY) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (HREADY) begin
                    if (dphase_q && !hwrite_q) begin
                        rdata_d  = HRDATA;
                        rvalid_d = 1'b1;
                    end
                    if (state_q == ST_DATA) begin
                        state_d  = ST_IDLE;
                        dphase_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        dphase_d = 1'b1;
                        if (left_q == 4'd0) begin
                            htrans_d = TR_IDLE;
                            state_d  = ST_DATA;
                        end else begin
                            htrans_d = TR_SEQ;
                            haddr_d  = haddr_q + step;
                            left_d   = left_q - 4'd1;
                        end
                    end
                end
            end
            ST_ERR: begin
                htrans_d = TR_IDLE;
                if (HREADY) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            haddr_q  <= '0;
            htrans_q <= TR_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= 3'd0;
            hburst_q <= 3'd0;
            left_q   <= 4'd0;
            dphase_q <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            hburst_q <= hburst_d;
            left_q   <= left_d;
            dphase_q <= dphase_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // holding ready low during done keeps an idle cycle between commands
    assign cmd_ready_o   = (state_q == ST_IDLE) && !done_q;
    assign wdata_ack_o   = dphase_q && hwrite_q && HREADY && !HRESP;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign HADDR         = haddr_q;
    assign HTRANS        = htrans_q;
    assign HWRITE        = hwrite_q;
    assign HSIZE         = hsize_q;
    assign HBURST        = hburst_q;
    assign HPROT         = 4'b0011;
    assign HMASTLOCK     = 1'b0;
    assign HWDATA        = wdata_i;

endmodule

// File: tb/tb_ahb3lite_cmd_master.sv
// Bench for ahb3lite_cmd_master: protocol-level slave plus
// command scoreboard, directed cases then random commands.
`timescale 1ns/1ps
module tb_ahb3lite_cmd_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_addr_i;
    logic        cmd_write_i;
    logic [2:0]  cmd_size_i;
    logic [2:0]  cmd_burst_i;
    logic [31:0] wdata_i;
    logic        wdata_ack_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    always #5 HCLK = ~HCLK;

    ahb3lite_cmd_master #(.HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_write_i(cmd_write_i),
        .cmd_size_i(cmd_size_i), .cmd_burst_i(cmd_burst_i),
        .wdata_i(wdata_i), .wdata_ack_o(wdata_ack_o),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .done_o(done_o), .err_o(err_o),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [2:0]  size;
        logic [2:0]  burst;
        int          err_beat;
        int          wait_beat;
        bit          rnd_wait;
        logic [31:0] wbase;
    } cmd_t;

    cmd_t        cq[$];
    cmd_t        cur;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_done_cyc = -1;
    bit          act, dp_valid, done_due, err_exp, rv_due, stall_prev, waited;
    int          dp_beat, issued, completed, acks, err_st, nbeats, rv_cnt;
    int          n_done, n_errp;
    logic [31:0] rv_val, prev_haddr, last_addr;
    logic [1:0]  prev_htrans;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int beats_of(input logic [2:0] b);
        case (b)
            3'b011:  return 4;
            3'b101:  return 8;
            3'b111:  return 16;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] beat_addr(input cmd_t c, input int i);
        return c.addr + (32'(i) << c.size);
    endfunction

    function automatic logic [31:0] wexp(input cmd_t c, input int i);
        return c.wbase + 32'(i);
    endfunction

    function automatic cmd_t mk(input logic [31:0] a, input bit w,
                                input logic [2:0] s, input logic [2:0] b,
                                input int eb, input int wb, input bit rw,
                                input logic [31:0] wd);
        cmd_t c;
        c.addr = a; c.wr = w; c.size = s; c.burst = b;
        c.err_beat = eb; c.wait_beat = wb; c.rnd_wait = rw; c.wbase = wd;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        int nb;
        int span;
        case ($urandom_range(3))
            0:       c.burst = 3'b000;
            1:       c.burst = 3'b011;
            2:       c.burst = 3'b101;
            default: c.burst = 3'b111;
        endcase
        c.size = 3'($urandom_range(2));
        nb = beats_of(c.burst);
        span = 1024 >> c.size;
        c.addr = ($urandom() & 32'hFFFF_FC00)
               | (32'($urandom_range(span - nb)) << c.size);
        c.wr = 1'($urandom_range(1));
        c.err_beat = ($urandom_range(4) == 0) ? int'($urandom_range(nb - 1)) : -1;
        c.wait_beat = -1;
        c.rnd_wait = 1'b1;
        c.wbase = $urandom();
        return c;
    endfunction

    task automatic drive();
        if (cq.size() > 0) begin
            cmd_valid_i = 1'b1;
            cmd_addr_i  = cq[0].addr;
            cmd_write_i = cq[0].wr;
            cmd_size_i  = cq[0].size;
            cmd_burst_i = cq[0].burst;
        end else begin
            cmd_valid_i = 1'b0;
            cmd_addr_i  = $urandom();
            cmd_write_i = 1'($urandom_range(1));
            cmd_size_i  = 3'($urandom_range(7));
            cmd_burst_i = 3'($urandom_range(7));
        end
        HREADY = 1'b1;
        HRESP  = 1'b0;
        if (act && err_st == 1) begin
            HRESP = 1'b1;
        end else if (act && dp_valid && err_st == 0 && dp_beat == cur.err_beat) begin
            HREADY = 1'b0;
            HRESP  = 1'b1;
        end else if (act && dp_valid && dp_beat == cur.wait_beat && !waited) begin
            HREADY = 1'b0;
            waited = 1'b1;
        end else if (act && dp_valid && cur.rnd_wait && $urandom_range(3) == 0) begin
            HREADY = 1'b0;
        end
        HRDATA  = $urandom();
        wdata_i = (act && cur.wr) ? wexp(cur, acks) : $urandom();
    endtask

    task automatic sample();
        bit ack_exp;
        cyc++;
        chk("ready", cmd_ready_o, !act);
        chk("done", done_o, done_due);
        chk("err", err_o, done_due && err_exp);
        chk("rvalid", rdata_valid_o, rv_due);
        chk("hprot", {HMASTLOCK, HPROT}, 5'b00011);
        if (rv_due) begin
            chk("rdata", rdata_o, rv_val);
            if (rdata_valid_o) rv_cnt++;
        end
        rv_due = 1'b0;
        if (done_o) n_done++;
        if (err_o) n_errp++;
        if (done_due) begin
            chk("idle_end", HTRANS, 2'b00);
            act = 1'b0;
            done_due = 1'b0;
            last_done_cyc = cyc;
        end else if (!act) begin
            chk("idle", HTRANS, 2'b00);
        end
        if (stall_prev) begin
            chk("hold_addr", HADDR, prev_haddr);
            chk("hold_trans", HTRANS, prev_htrans);
        end
        ack_exp = act && dp_valid && cur.wr && HREADY && !HRESP;
        chk("wack", wdata_ack_o, ack_exp);
        if (act && dp_valid && HREADY && !HRESP) begin
            if (cur.wr) begin
                chk("hwdata", HWDATA, wexp(cur, dp_beat));
                acks++;
            end else begin
                rv_due = 1'b1;
                rv_val = HRDATA;
            end
            completed++;
            if (completed == nbeats) begin
                done_due = 1'b1;
                err_exp = 1'b0;
            end
        end
        if (act && err_st == 1 && HREADY && HRESP) begin
            chk("cancel", HTRANS, 2'b00);
            done_due = 1'b1;
            err_exp = 1'b1;
            err_st = 2;
            dp_valid = 1'b0;
        end else if (act && dp_valid && HRESP && !HREADY) begin
            err_st = 1;
        end
        if (act && err_st == 0 && HREADY) begin
            if (HTRANS != 2'b00) begin
                chk("beats", issued < nbeats, 1'b1);
                chk("htrans", HTRANS, (issued == 0) ? 2'b10 : 2'b11);
                chk("haddr", HADDR, beat_addr(cur, issued));
                chk("hwrite", HWRITE, cur.wr);
                chk("hsize", HSIZE, cur.size);
                chk("hburst", HBURST, cur.burst);
                last_addr = HADDR;
                dp_valid = 1'b1;
                dp_beat = issued;
                issued++;
            end else begin
                dp_valid = 1'b0;
            end
        end
        if (cmd_valid_i && cmd_ready_o) begin
            chk("after_done", cyc > last_done_cyc, 1'b1);
            cur = cq.pop_front();
            act = 1'b1;
            nbeats = beats_of(cur.burst);
            issued = 0; completed = 0; acks = 0; rv_cnt = 0;
            err_st = 0; waited = 1'b0; dp_valid = 1'b0;
        end
        stall_prev = act && !HREADY && !HRESP;
        prev_haddr = HADDR;
        prev_htrans = HTRANS;
    endtask

    task automatic run(input int max_cyc, input int stop_at);
        bit fin;
        fin = 1'b0;
        for (int k = 0; k < max_cyc && !fin; k++) begin
            @(posedge HCLK);
            #1;
            drive();
            @(negedge HCLK);
            sample();
            fin = (cq.size() == 0 && !act && !rv_due && !done_due)
               || (stop_at > 0 && act && issued >= stop_at);
        end
        chk("finish", fin, 1'b1);
    endtask

    initial begin
        int d0, e0;
        HRESETn = 1'b0;
        cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_write_i = 1'b0;
        cmd_size_i = '0; cmd_burst_i = '0; wdata_i = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        act = 0; dp_valid = 0; done_due = 0; err_exp = 0; rv_due = 0;
        stall_prev = 0; waited = 0; dp_beat = 0; issued = 0; completed = 0;
        acks = 0; err_st = 0; nbeats = 1; rv_cnt = 0; n_done = 0; n_errp = 0;
        rv_val = '0; prev_haddr = '0; prev_htrans = '0; last_addr = '0;
        #12;
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", HWRITE, 1'b0);
        chk("rst_hsize", HSIZE, 3'd0);
        chk("rst_hburst", HBURST, 3'd0);
        chk("rst_ready", cmd_ready_o, 1'b1);
        chk("rst_wack", wdata_ack_o, 1'b0);
        chk("rst_rvalid", rdata_valid_o, 1'b0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        cq.push_back(mk(32'h10, 1'b1, 3'd2, 3'b000, -1, -1, 1'b0, 32'hDEADBEEF));
        d0 = n_done;
        run(100, 0);
        chk("single_acks", acks, 1);
        chk("single_done", n_done - d0, 1);

        cq.push_back(mk(32'h100, 1'b0, 3'd2, 3'b011, -1, 1, 1'b0, 32'h0));
        run(100, 0);
        chk("incr4_rv", rv_cnt, 4);
        chk("incr4_last", last_addr, 32'h10C);

        cq.push_back(mk(32'h200, 1'b1, 3'd2, 3'b101, 2, -1, 1'b0, 32'h5500_0000));
        d0 = n_done;
        e0 = n_errp;
        run(100, 0);
        chk("err_acks", acks, 2);
        chk("err_pulse", n_errp - e0, 1);
        chk("err_done", n_done - d0, 1);

        cq.push_back(mk(32'h2000, 1'b1, 3'd2, 3'b101, -1, -1, 1'b0, 32'h1000));
        d0 = n_done;
        run(100, 3);
        #1 HRESETn = 1'b0;
        cmd_valid_i = 1'b0;
        #1;
        chk("mid_htrans", HTRANS, 2'b00);
        chk("mid_ready", cmd_ready_o, 1'b1);
        chk("mid_done", done_o, 1'b0);
        chk("mid_haddr", HADDR, 32'h0);
        act = 0; dp_valid = 0; done_due = 0; rv_due = 0; err_st = 0;
        stall_prev = 0; issued = 0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;

        cq.push_back(mk(32'h3, 1'b0, 3'd0, 3'b111, -1, -1, 1'b1, 32'h0));
        run(200, 0);
        chk("mid_no_done", n_done - d0, 1);
        chk("b16_rv", rv_cnt, 16);
        chk("b16_last", last_addr, 32'h12);

        cq.push_back(mk(32'h40, 1'b0, 3'd2, 3'b000, -1, -1, 1'b1, 32'h0));
        cq.push_back(mk(32'h80, 1'b1, 3'd2, 3'b011, -1, -1, 1'b1, 32'hA0A0_0000));
        d0 = n_done;
        run(200, 0);
        chk("b2b_done", n_done - d0, 2);
        chk("b2b_acks", acks, 4);

        for (int n = 0; n < 60; n++) begin
            int np;
            np = $urandom_range(1, 2);
            for (int j = 0; j < np; j++) cq.push_back(rnd_cmd());
            run(400, 0);
            repeat ($urandom_range(0, 2)) @(posedge HCLK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb3lite_cmd_master.md
AHB3LITE_CMD_MASTER -- requirements
Module: ahb3lite_cmd_master

Interface
REQ-001 Parameter HADDR_SIZE, default 32, sets the width of the address bus and of cmd_addr.
REQ-002 Parameter HDATA_SIZE, default 32, sets the data bus width; legal values are 8..1024, powers of 2.
REQ-003 HCLK  in  1  single clock, rising edge.
REQ-004 HRESETn  in  1  asynchronous active-low reset.
REQ-005 cmd_valid_i  in  1  command request.
REQ-006 cmd_ready_o  out  1  command accepted on cmd_valid_i & cmd_ready_o.
REQ-007 cmd_addr_i  in  HADDR_SIZE  start address; must be aligned to cmd_size_i.
REQ-008 cmd_write_i  in  1  1 selects write, 0 selects read.
REQ-009 cmd_size_i  in  3  HSIZE encoding; must not exceed HDATA_SIZE.
REQ-010 cmd_burst_i  in  3  HBURST encoding; only SINGLE, INCR4, INCR8 and INCR16 are legal.
REQ-011 wdata_i  in  HDATA_SIZE  write data for the current write beat.
REQ-012 wdata_ack_o  out  1  write beat completed; caller presents the next beat.
REQ-013 rdata_o  out  HDATA_SIZE  read beat data.
REQ-014 rdata_valid_o  out  1  rdata_o valid for this cycle.
REQ-015 done_o  out  1  one-cycle pulse when a command terminates.
REQ-016 err_o  out  1  one-cycle pulse, coincident with done_o, when a command terminated on ERROR.
REQ-017 HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA  out  standard widths  AHB3-Lite master outputs.
REQ-018 HRDATA, HREADY, HRESP  in  standard widths  AHB3-Lite master inputs.

Function
REQ-019 FSM states SHALL be IDLE, ADDR, DATA and ERR.
REQ-020 cmd_ready_o SHALL be 1 only in IDLE.
  - On acceptance the block latches address, write, size and burst.
  - Beat count is 1/4/8/16 per burst type.
  - Next state is ADDR.
REQ-021 In ADDR and DATA, the address-phase outputs SHALL advance only on cycles where HREADY=1.
  - First beat drives HTRANS=NONSEQ, later beats drive SEQ.
  - HBURST, HSIZE and HWRITE are held constant for the whole command.
REQ-022 Beat address SHALL increment by (1<<size) per beat, with no wrap and no 1KB check; the caller keeps bursts inside a 1KB boundary.
REQ-023 Address and data phases SHALL be pipelined: the address phase of beat n+1 overlaps the data phase of beat n.
REQ-024 After the last address phase completes, HTRANS SHALL be IDLE until the final data phase completes; the FSM then returns to IDLE and done_o pulses.
REQ-025 The block SHALL never issue BUSY transfers.
REQ-026 In IDLE and ERR, HTRANS SHALL be IDLE.
REQ-027 HPROT SHALL be 4'b0011 and HMASTLOCK SHALL be 0 at all times.
REQ-028 Write data phase:
  - HWDATA = wdata_i, combinational.
  - wdata_ack_o = 1 in each cycle where a write data phase completes with HREADY=1 and HRESP=OKAY.
REQ-029 Read data phase: on HREADY=1 and HRESP=OKAY, rdata_o <= HRDATA and rdata_valid_o pulses in the next cycle, registered.
REQ-030 ERROR, first cycle (HRESP=1, HREADY=0):
  - HTRANS is driven IDLE in the following cycle, cancelling the pending beat.
  - FSM enters ERR.
  - No wdata_ack_o or rdata_valid_o is issued for the failed beat.
REQ-031 ERROR, second cycle (HRESP=1, HREADY=1): FSM returns to IDLE, and done_o and err_o pulse in the next cycle.
REQ-032 Wait states (HREADY=0 with HRESP=OKAY) SHALL hold all master outputs and the internal counters unchanged.
REQ-033 A command is never aborted by the block except on ERROR.
REQ-034 cmd_valid_i is ignored outside IDLE.
REQ-035 There is at least one HTRANS=IDLE cycle between commands.

Reset
REQ-036 While HRESETn=0, all outputs SHALL take these values asynchronously:
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0.
  - cmd_ready_o=1.
  - wdata_ack_o, rdata_valid_o, done_o, err_o = 0; rdata_o = 0.
  - FSM = IDLE.
REQ-037 Reset asserted mid-burst SHALL abandon the command with no done_o pulse.
  - The first command accepted after release starts with NONSEQ.

Verification
REQ-038 Reset mid-INCR8 -> HTRANS=IDLE immediately, cmd_ready_o=1, no done_o.
REQ-039 SINGLE write, addr 0x10, size WORD, wdata 0xDEADBEEF, HREADY=1:
  - NONSEQ with HADDR 0x10 one cycle after acceptance.
  - HWDATA 0xDEADBEEF in the next cycle.
  - One wdata_ack_o, then done_o.
REQ-040 INCR4 read at 0x100, one wait state on beat 2:
  - HADDR sequence 0x100, 0x104, 0x108, 0x10C; HTRANS NONSEQ, SEQ, SEQ, SEQ.
  - Four rdata_valid_o pulses with the matching HRDATA values.
  - HADDR stalls at 0x108 during the wait.
REQ-041 INCR8 write, ERROR on beat 3:
  - HTRANS=IDLE after the first ERROR cycle.
  - Exactly 2 wdata_ack_o pulses.
  - done_o and err_o together, then cmd_ready_o=1.
REQ-042 Back-to-back commands (SINGLE read, then INCR4 write, cmd_valid_i held high):
  - Second command is accepted only after done_o of the first.
  - At least one HTRANS=IDLE cycle between them.
REQ-043 HSIZE BYTE INCR16 read at 0x3 -> HADDR increments by 1 per beat, 0x3..0x12.
